// File: rtl/snake_pkg.sv
// Shared snake types: the direction encoding and its opposite-direction lookup.
package snake_pkg;
  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } direction;

  function automatic direction opposite(direction d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      RIGHT:   return LEFT;
      default: return NONE;
    endcase
  endfunction
endpackage

// File: rtl/move_sched_if.sv
// Bundle between the front-ends (master) and move_sched (slave).
interface move_sched_if;
  logic                start;
  snake_pkg::direction btn_dir;
  logic                rx_valid;
  snake_pkg::direction rx_dir;
  logic                collision;
  logic                tx_ready;
  snake_pkg::direction dir1;
  snake_pkg::direction dir2;
  logic                step1;
  logic                step2;
  logic                tx_valid;
  snake_pkg::direction tx_dir;
  logic                com_err;
  logic [1:0]          state;

  modport master (
    output start, btn_dir, rx_valid, rx_dir, collision, tx_ready,
    input  dir1, dir2, step1, step2, tx_valid, tx_dir, com_err, state
  );
  modport slave (
    input  start, btn_dir, rx_valid, rx_dir, collision, tx_ready,
    output dir1, dir2, step1, step2, tx_valid, tx_dir, com_err, state
  );
endinterface

// File: rtl/move_sched.sv
// Game-tick scheduler, direction filter, step1/step2 arbiter and peer-link watchdog.
// Define SNAKE_SOLO_EN to compile out the remote path (rx, tx, step2, watchdog).
module move_sched #(
  parameter int TICK_CYCLES   = 16_250_000,
  parameter int TIMEOUT_TICKS = 2
) (
  input  logic         clk,
  input  logic         rst,
  move_sched_if.slave  bus
);
  import snake_pkg::*;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  state_t        st, st_nxt;
  logic [CW-1:0] cnt;
  direction      dir1, dir2, pend1, pend_nxt, tx_dir;
  logic          step1, step2, tx_valid, com_err;
  logic          run, tick, ending, clear, btn_ok;

  assign run      = (st == RUN);
  assign tick     = run && (cnt == CW'(TICK_CYCLES - 1));
  assign ending   = run && (bus.collision || com_err);
  // OVER->IDLE reloads every register except the state itself
  assign clear    = (st == OVER) && bus.start;
  assign btn_ok   = (bus.btn_dir != NONE) && (bus.btn_dir != opposite(dir1));
  assign pend_nxt = btn_ok ? bus.btn_dir : pend1;

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (bus.start) st_nxt = RUN;
      RUN:     if (bus.collision || com_err) st_nxt = OVER;
      OVER:    if (bus.start) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // Local snake: tick counter, filtered direction, step1
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt   <= '0;
      pend1 <= UP;
      dir1  <= UP;
      step1 <= 1'b0;
    end else if (ending) begin
      cnt   <= '0;
      step1 <= 1'b0;
    end else if (run) begin
      cnt   <= tick ? '0 : cnt + 1'b1;
      pend1 <= pend_nxt;
      step1 <= tick;
      if (tick) dir1 <= pend_nxt;
    end
  end

`ifdef SNAKE_SOLO_EN
  assign dir2     = UP;
  assign step2    = 1'b0;
  assign tx_valid = 1'b0;
  assign tx_dir   = NONE;
  assign com_err  = 1'b0;
`else
  localparam int MW = $clog2(TIMEOUT_TICKS + 1);

  logic [MW-1:0] miss;
  logic          defer;

  // Remote snake, TX word and watchdog. step2 yields to step1 by one cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      dir2     <= UP;
      step2    <= 1'b0;
      defer    <= 1'b0;
      tx_valid <= 1'b0;
      tx_dir   <= NONE;
      com_err  <= 1'b0;
      miss     <= '0;
    end else if (run) begin
      if (bus.rx_valid)
        miss <= '0;
      else if (tick && miss != MW'(TIMEOUT_TICKS))
        miss <= miss + 1'b1;
      if (tick && !bus.rx_valid && miss >= MW'(TIMEOUT_TICKS - 1))
        com_err <= 1'b1;

      if (ending) begin
        step2    <= 1'b0;
        defer    <= 1'b0;
        tx_valid <= 1'b0;
      end else begin
        if (bus.rx_valid) dir2 <= bus.rx_dir;
        step2 <= (bus.rx_valid || defer) && !tick;
        defer <= bus.rx_valid && tick;
        if (tick) begin
          tx_valid <= 1'b1;
          tx_dir   <= pend_nxt;
        end else if (tx_valid && bus.tx_ready) begin
          tx_valid <= 1'b0;
        end
      end
    end
  end
`endif

  assign bus.dir1     = dir1;
  assign bus.dir2     = dir2;
  assign bus.step1    = step1;
  assign bus.step2    = step2;
  assign bus.tx_valid = tx_valid;
  assign bus.tx_dir   = tx_dir;
  assign bus.com_err  = com_err;
  assign bus.state    = st;
endmodule

// File: tb/tb_move_sched.sv
// Randomised bench for move_sched against a cycle-indexed behavioural model.
module tb_move_sched;
  import snake_pkg::*;

  localparam int T  = 8;
  localparam int TO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  move_sched_if bus ();
  move_sched #(.TICK_CYCLES(T), .TIMEOUT_TICKS(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: ticks are placed by edge index relative to the RUN entry edge,
  // step2 by an absolute due edge.
  int       now = 0;
  int       run_entry, miss, due2;
  int       e_state;
  direction e_dir1, e_dir2, e_txdir, pend;
  bit       e_step1, e_step2, e_txv, e_err;

  function automatic bit is_opp(direction a, direction b);
    return (a == UP && b == DOWN) || (a == DOWN && b == UP) ||
           (a == LEFT && b == RIGHT) || (a == RIGHT && b == LEFT);
  endfunction

  function void model_reset();
    e_state = 0; e_dir1 = UP; e_dir2 = UP; pend = UP; e_txdir = NONE;
    e_step1 = 0; e_step2 = 0; e_txv = 0; e_err = 0;
    miss = 0; due2 = -1; run_entry = 0;
  endfunction

  function void model_step();
    bit tk, endg;
    now++;
    if (rst) begin
      model_reset();
    end else if (e_state == 0) begin
      if (bus.start) begin e_state = 1; run_entry = now; end
    end else if (e_state == 2) begin
      if (bus.start) model_reset();
    end else begin
      tk   = ((now - run_entry) % T) == 0;
      endg = bus.collision || e_err;
      if (bus.btn_dir != NONE && !is_opp(bus.btn_dir, e_dir1)) pend = bus.btn_dir;
      if (bus.rx_valid) miss = 0;
      else if (tk) begin
        miss++;
        if (miss >= TO) e_err = 1;
      end
      if (endg) begin
        e_state = 2; e_step1 = 0; e_step2 = 0; e_txv = 0; due2 = -1;
      end else begin
        e_step1 = tk;
        if (tk) begin e_dir1 = pend; e_txdir = pend; e_txv = 1; end
        else if (e_txv && bus.tx_ready) e_txv = 0;
        e_step2 = (due2 == now);
        if (bus.rx_valid) begin
          e_dir2 = bus.rx_dir;
          if (tk) due2 = now + 1;
          else    e_step2 = 1;
        end
      end
    end
  endfunction

  function void chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dut=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function void compare_all();
    chk("state",    int'(bus.state),    e_state);
    chk("dir1",     int'(bus.dir1),     int'(e_dir1));
    chk("dir2",     int'(bus.dir2),     int'(e_dir2));
    chk("step1",    int'(bus.step1),    int'(e_step1));
    chk("step2",    int'(bus.step2),    int'(e_step2));
    chk("tx_valid", int'(bus.tx_valid), int'(e_txv));
    chk("tx_dir",   int'(bus.tx_dir),   int'(e_txdir));
    chk("com_err",  int'(bus.com_err),  int'(e_err));
    chk("step_excl", int'(bus.step1 & bus.step2), 0);
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    model_reset();
    bus.start = 0; bus.btn_dir = NONE; bus.rx_valid = 0; bus.rx_dir = NONE;
    bus.collision = 0; bus.tx_ready = 0;
    rst = 1;
    cyc(); cyc();
    rst = 0;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_dir1", int'(bus.dir1), int'(UP));
    chk("rst_txdir", int'(bus.tx_dir), int'(NONE));

    // Tick cadence: first step1 8 edges after RUN entry
    bus.start = 1; cyc(); bus.start = 0;
    chk("run_state", int'(bus.state), 1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("first_step1", int'(bus.step1), int'(k == 8));
    end
    chk("tick1_dir1", int'(bus.dir1), int'(UP));
    chk("tick1_txv", int'(bus.tx_valid), 1);

    // DOWN rejected, LEFT accepted; rx in the tick cycle defers step2
    for (int k = 9; k <= 16; k++) begin
      bus.btn_dir = (k <= 11) ? DOWN : LEFT;
      if (k == 16) begin bus.rx_valid = 1; bus.rx_dir = RIGHT; end
      cyc();
      chk("period_step1", int'(bus.step1), int'(k == 16));
    end
    chk("tick2_dir1", int'(bus.dir1), int'(LEFT));
    chk("tick2_step2", int'(bus.step2), 0);
    bus.rx_valid = 0; bus.btn_dir = NONE;
    cyc();
    chk("defer_step2", int'(bus.step2), 1);
    chk("defer_dir2", int'(bus.dir2), int'(RIGHT));
    chk("tx_hold_valid", int'(bus.tx_valid), 1);
    chk("tx_hold_dir", int'(bus.tx_dir), int'(LEFT));
    bus.tx_ready = 1;
    cyc();
    chk("tx_done", int'(bus.tx_valid), 0);
    bus.tx_ready = 0;

    // Watchdog: ticks at edges 24 and 32 with no rx
    for (int k = 19; k <= 32; k++) cyc();
    chk("wd_err", int'(bus.com_err), 1);
    chk("wd_still_run", int'(bus.state), 1);
    cyc();
    chk("wd_over", int'(bus.state), 2);
    chk("wd_txv_drop", int'(bus.tx_valid), 0);
    bus.start = 1; cyc(); bus.start = 0;
    chk("clear_state", int'(bus.state), 0);
    chk("clear_err", int'(bus.com_err), 0);

    // Collision while step2 is deferred
    bus.start = 1; cyc(); bus.start = 0;
    for (int k = 1; k <= 7; k++) cyc();
    bus.rx_valid = 1; bus.rx_dir = DOWN;
    cyc();
    chk("col_step1", int'(bus.step1), 1);
    bus.rx_valid = 0; bus.collision = 1;
    cyc();
    chk("col_over", int'(bus.state), 2);
    chk("col_step2_dropped", int'(bus.step2), 0);
    bus.collision = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("over_quiet", int'(bus.step1 | bus.step2 | bus.tx_valid), 0);
    end

    // rst mid-game with a tx word pending
    bus.start = 1; cyc(); cyc(); bus.start = 0;
    bus.btn_dir = RIGHT; bus.rx_valid = 1; bus.rx_dir = LEFT;
    for (int k = 0; k < 9; k++) cyc();
    chk("pre_rst_dir1", int'(bus.dir1), int'(RIGHT));
    rst = 1; bus.btn_dir = NONE; bus.rx_valid = 0;
    cyc();
    rst = 0;
    chk("mid_rst_state", int'(bus.state), 0);
    chk("mid_rst_dir1", int'(bus.dir1), int'(UP));
    chk("mid_rst_dir2", int'(bus.dir2), int'(UP));
    chk("mid_rst_txv", int'(bus.tx_valid), 0);

    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      rst           = ($urandom_range(0, 499) == 0);
      bus.start     = ($urandom_range(0, 11) == 0);
      bus.btn_dir   = direction'($urandom_range(0, 4));
      bus.rx_valid  = ($urandom_range(0, 4) == 0);
      bus.rx_dir    = direction'($urandom_range(0, 4));
      bus.collision = ($urandom_range(0, 149) == 0);
      bus.tx_ready  = ($urandom_range(0, 1) == 1);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/move_sched.md
# move_sched

Game-tick scheduler and direction arbiter that sequences the snake move datapath. Generates the periodic local move step, filters and commits player directions, and serialises local and remote snake updates so they never hit the map in the same cycle. Runs the peer-link handshake and watchdog. Sits between the input/UART front-ends and the move/collision logic.

## Interface
- TICK_CYCLES, 16_250_000: clk cycles per game tick (4 Hz at 65 MHz); minimum 4.
- TIMEOUT_TICKS, 2: consecutive local ticks without a remote direction before com_err.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  level; IDLE->RUN and OVER->IDLE.
- btn_dir  in  direction  local requested direction (snake_pkg::direction), sampled every clk.
- rx_valid  in  1  one-cycle strobe: remote direction received.
- rx_dir  in  direction  remote direction, valid with rx_valid.
- collision  in  1  level from collision checker; ends the game.
- tx_ready  in  1  UART TX accepts the word when tx_valid&&tx_ready.
- dir1  out  direction  committed local direction.
- dir2  out  direction  committed remote direction.
- step1  out  1  one-cycle pulse: apply dir1 to snake 1.
- step2  out  1  one-cycle pulse: apply dir2 to snake 2.
- tx_valid  out  1  local direction pending transmission.
- tx_dir  out  direction  direction to transmit.
- com_err  out  1  sticky link-failure flag.
- state  out  2  0=IDLE, 1=RUN, 2=OVER.

## Operation
- Reset values: state=IDLE, dir1=UP, dir2=UP, pend1=UP, step1=0, step2=0, tx_valid=0, tx_dir=NONE, com_err=0, tick counter=0, miss counter=0, step2 deferral flag=0.
- FSM: IDLE->RUN on start; RUN->OVER on collision or com_err; OVER->IDLE on start. Clearing to IDLE reloads all reset values except state.
- Tick counter runs only in RUN, 0..TICK_CYCLES-1, wraps to 0. Held at 0 in IDLE/OVER.
- Direction filter (RUN only): btn_dir latched into pend1 when not NONE and not the opposite of dir1 (UP/DOWN, LEFT/RIGHT). Latest legal request before the tick wins. Illegal or NONE requests are ignored.
- At tick: dir1<=pend1, step1 pulses, tx_dir<=pend1, tx_valid<=1.
- TX: tx_valid held until tx_valid&&tx_ready. If a new tick arrives with tx still pending, tx_dir is overwritten with the new value; no second word is queued.
- Remote: rx_valid in RUN latches dir2<=rx_dir (NONE accepted, means hold) and schedules step2. Outside RUN rx_valid is ignored.
- Arbitration: step1 and step2 are never high in the same cycle. If both are due in the same cycle, step1 goes first and step2 fires the following cycle. An rx_valid arriving during a deferral overwrites dir2 and still produces only one step2.
- Watchdog: miss counter increments at each tick and clears on any accepted rx_valid. com_err sets when miss counter reaches TIMEOUT_TICKS. It clears only via rst or the OVER->IDLE transition.
- collision and com_err in the same cycle: both lead to OVER; com_err is still recorded.

## Timing
- step1 is registered and asserted exactly one cycle after the counter reaches TICK_CYCLES-1. dir1 changes on the same edge and is stable while step1 is high.
- step2 is asserted the cycle after rx_valid, or two cycles after if deferred. dir2 is stable while step2 is high.
- A btn_dir request sampled in the cycle the counter equals TICK_CYCLES-1 is included in that tick.
- Entering OVER: step1, step2 and tx_valid go low on the next cycle. Pending step2 and tx words are dropped.
- rst mid-game: all outputs take reset values on the next edge regardless of handshakes in flight.

## Configuration
- SNAKE_SOLO_EN defined: remote path compiled out. rx_valid is ignored, step2 is held 0, dir2 is held UP, tx_valid is held 0, com_err is held 0, and the watchdog is removed.
- SNAKE_SOLO_EN undefined: full two-player behaviour as above.

## Test plan
- Bench parameters for all scenarios: TICK_CYCLES=8, TIMEOUT_TICKS=2.
- Reset, then start -> state=1. First step1 on cycle 8 after entering RUN, dir1=UP; next step1 exactly 8 cycles later.
- dir1=UP; btn_dir=DOWN for 3 cycles, then LEFT before the tick -> DOWN rejected, tick commits dir1=LEFT.
- rx_valid with rx_dir=RIGHT in the same cycle step1 is scheduled -> step1 that cycle, step2 next cycle with dir2=RIGHT, never both high together.
- tx_ready held 0 across two ticks (dir1 changes UP->LEFT) -> tx_valid stays 1, tx_dir=LEFT; tx_ready=1 gives a single handshake and then tx_valid=0.
- No rx_valid for 2 ticks -> com_err=1 and state=2 on the next cycle. start -> state=0, com_err=0.
- collision asserted mid-tick with step2 deferred -> state=2, no further step1/step2/tx_valid. rst mid-game -> reset values on the next edge.
